// File: rtl/deskew_align_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : deskew_align_monitor
//  Description : Supervisory FSM for the deskew datapath. Sequences deskew
//                bring-up after AM lock, checks post-deskew lane alignment
//                from the start-of-lane tags and issues resync on bad skew,
//                deskew timeout or persistent misalignment. Owns align_status.
//  Revision    : 1.0 - initial release
// ============================================================================
module deskew_align_monitor #(
  parameter int N_LANES        = 20,
  parameter int AM_PERIOD      = 16384,
  parameter int MAX_INVALID    = 3,
  parameter int DESKEW_TIMEOUT = 65536,
  parameter int RESYNC_CYCLES  = 4,
  parameter int NB_ERR         = $clog2(MAX_INVALID + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_am_lock,
  input  logic               i_deskew_done,
  input  logic               i_invalid_skew,
  input  logic [N_LANES-1:0] i_tags,
  output logic [N_LANES-1:0] o_resync,
  output logic               o_align_status,
  output logic [NB_ERR-1:0]  o_err_count,
  output logic [7:0]         o_resync_count
);

  // Counter widths sized so each counter tops out exactly at its terminal value.
  localparam int PC_W   = (AM_PERIOD > 1)      ? $clog2(AM_PERIOD)      : 1;
  localparam int TMR_W  = (DESKEW_TIMEOUT > 1) ? $clog2(DESKEW_TIMEOUT) : 1;
  localparam int HOLD_W = (RESYNC_CYCLES > 1)  ? $clog2(RESYNC_CYCLES)  : 1;

  localparam logic [PC_W-1:0]   C_PC_LAST   = PC_W'(AM_PERIOD - 1);
  localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(DESKEW_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESYNC_CYCLES - 1);
  localparam logic [NB_ERR-1:0] C_ERR_MAX   = NB_ERR'(MAX_INVALID);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_DESKEW = 2'd1,
    S_ALIGNED     = 2'd2,
    S_RESYNC      = 2'd3
  } state_t;

  state_t               r_state;
  logic [PC_W-1:0]      r_pc;
  logic [TMR_W-1:0]     r_timer;
  logic [HOLD_W-1:0]    r_hold;
  logic [NB_ERR-1:0]    r_err;
  logic [N_LANES-1:0]   r_resync;
  logic                 r_align;
  logic [7:0]           r_rcount;

  logic                 w_tags_all;
  logic                 w_tags_any;
  logic                 w_am_bad;
  logic [NB_ERR-1:0]    w_err_inc;
  logic                 w_err_hit;
  logic [7:0]           w_rcount_inc;

  // Classify the current AM slot and precompute the saturating increments.
  always_comb begin
    w_tags_all   = &i_tags;
    w_tags_any   = |i_tags;
    // Misaligned tags, or silence through the whole expected AM period.
    w_am_bad     = (w_tags_any && !w_tags_all) || (!w_tags_any && (r_pc == C_PC_LAST));
    w_err_inc    = (r_err == C_ERR_MAX) ? r_err : r_err + NB_ERR'(1);
    w_err_hit    = (w_err_inc == C_ERR_MAX);
    w_rcount_inc = (r_rcount == 8'hFF) ? r_rcount : r_rcount + 8'd1;
  end

  // Supervisory FSM with all counters and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_timer  <= '0;
      r_hold   <= '0;
      r_err    <= '0;
      r_resync <= '0;
      r_align  <= 1'b0;
      r_rcount <= '0;
    end else if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          if (i_am_lock) begin
            r_state <= S_WAIT_DESKEW;
            r_timer <= '0;
            r_err   <= '0;
          end
        end

        S_WAIT_DESKEW: begin
          if (!i_am_lock) begin
            r_state <= S_IDLE;
          end else if (i_valid) begin
            // Bad skew wins over done; done wins over a coincident timeout.
            if (i_invalid_skew || (!i_deskew_done && (r_timer == C_TMR_LAST))) begin
              r_state  <= S_RESYNC;
              r_resync <= '1;
              r_hold   <= '0;
              r_rcount <= w_rcount_inc;
            end else if (i_deskew_done) begin
              r_state <= S_ALIGNED;
              r_align <= 1'b1;
              r_pc    <= '0;
              r_err   <= '0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
        end

        S_ALIGNED: begin
          if (!i_am_lock) begin
            r_state <= S_IDLE;
            r_align <= 1'b0;
            r_err   <= '0;
          end else if (i_valid) begin
            if (w_tags_all) begin
              // Good AM, including one landing in the expiry slot.
              r_pc  <= '0;
              r_err <= '0;
            end else if (w_am_bad) begin
              r_pc  <= '0;
              r_err <= w_err_inc;
              if (w_err_hit) begin
                r_state  <= S_RESYNC;
                r_align  <= 1'b0;
                r_resync <= '1;
                r_hold   <= '0;
                r_rcount <= w_rcount_inc;
              end
            end else begin
              r_pc <= r_pc + PC_W'(1);
            end
          end
        end

        S_RESYNC: begin
          // Hold runs on enabled clocks regardless of i_valid or lock state.
          if (r_hold == C_HOLD_LAST) begin
            r_state  <= S_IDLE;
            r_resync <= '0;
            r_err    <= '0;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_resync <= '0;
          r_align  <= 1'b0;
        end
      endcase
    end
  end

  assign o_resync       = r_resync;
  assign o_align_status = r_align;
  assign o_err_count    = r_err;
  assign o_resync_count = r_rcount;

endmodule
`default_nettype wire

// File: tb/tb_deskew_align_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deskew_align_monitor
//  Description : Self-checking bench for deskew_align_monitor: directed
//                scenarios with pinned literal values, then random stimulus,
//                all compared each cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deskew_align_monitor;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int MI = 3;
  localparam int TO = 32;
  localparam int RC = 2;
  localparam int NB = $clog2(MI + 1);

  logic          clk;
  logic          i_reset, i_enable, i_valid, i_am_lock, i_deskew_done, i_invalid_skew;
  logic [N-1:0]  i_tags;
  logic [N-1:0]  o_resync;
  logic          o_align_status;
  logic [NB-1:0] o_err_count;
  logic [7:0]    o_resync_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 idle, 1 waiting for deskew, 2 aligned, 3 resync.
  int m_mode, m_elapsed, m_since, m_err, m_left, m_count;

  deskew_align_monitor #(
    .N_LANES(N), .AM_PERIOD(P), .MAX_INVALID(MI),
    .DESKEW_TIMEOUT(TO), .RESYNC_CYCLES(RC), .NB_ERR(NB)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_am_lock(i_am_lock), .i_deskew_done(i_deskew_done),
    .i_invalid_skew(i_invalid_skew), .i_tags(i_tags),
    .o_resync(o_resync), .o_align_status(o_align_status),
    .o_err_count(o_err_count), .o_resync_count(o_resync_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void start_resync();
    m_mode  = 3;
    m_left  = RC;
    m_count = (m_count < 255) ? m_count + 1 : 255;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  function automatic void model_step(input logic rst, en, vld, lock, done, skew,
                                     input logic [N-1:0] tags);
    if (rst) begin
      m_mode = 0; m_elapsed = 0; m_since = 0; m_err = 0; m_left = 0; m_count = 0;
      return;
    end
    if (!en) return;
    case (m_mode)
      0: if (lock) begin m_mode = 1; m_elapsed = 0; m_err = 0; end
      1: begin
        if (!lock) m_mode = 0;
        else if (vld) begin
          if (skew) start_resync();
          else if (done) begin m_mode = 2; m_since = 0; m_err = 0; end
          else if (m_elapsed + 1 == TO) start_resync();
          else m_elapsed++;
        end
      end
      2: begin
        if (!lock) begin m_mode = 0; m_err = 0; end
        else if (vld) begin
          if (tags == {N{1'b1}}) begin m_since = 0; m_err = 0; end
          else if (tags != '0 || m_since + 1 == P) begin
            m_since = 0;
            if (m_err < MI) m_err++;
            if (m_err >= MI) start_resync();
          end else m_since++;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_err = 0; end
      end
    endcase
  endfunction

  task automatic check_model();
    chk("model_resync", o_resync, (m_mode == 3) ? 32'hF : 32'h0);
    chk("model_align", o_align_status, (m_mode == 2) ? 32'd1 : 32'd0);
    chk("model_err", o_err_count, m_err);
    chk("model_rcount", o_resync_count, m_count);
  endtask

  // Drive one cycle at the falling edge, step the model, check at the next falling edge.
  task automatic cyc(input logic rst, en, vld, lock, done, skew, input logic [N-1:0] tags);
    i_reset = rst; i_enable = en; i_valid = vld; i_am_lock = lock;
    i_deskew_done = done; i_invalid_skew = skew; i_tags = tags;
    model_step(rst, en, vld, lock, done, skew, tags);
    @(negedge clk);
    check_model();
  endtask

  task automatic vt(input logic [N-1:0] tags);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tags);
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) vt('0);
  endtask

  task automatic go_aligned();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_am_lock = 1'b0;
    i_deskew_done = 1'b0; i_invalid_skew = 1'b0; i_tags = '0;
    m_mode = 0; m_elapsed = 0; m_since = 0; m_err = 0; m_left = 0; m_count = 0;
    @(negedge clk);

    // Reset state.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_resync", o_resync, 0);
    chk("rst_align", o_align_status, 0);
    chk("rst_err", o_err_count, 0);
    chk("rst_count", o_resync_count, 0);

    // 1: lock, deskew_done on the 10th valid, good AM every 8.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("s1_wait_align", o_align_status, 0);
    zeros(9);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("s1_aligned", o_align_status, 1);
    for (int p = 0; p < 3; p++) begin zeros(7); vt(4'hF); end
    chk("s1_align_kept", o_align_status, 1);
    chk("s1_err", o_err_count, 0);
    chk("s1_no_resync", o_resync, 0);

    // 2: three misaligned AMs.
    vt(4'hB);  chk("s2_err1", o_err_count, 1);
    zeros(7); vt(4'hB);  chk("s2_err2", o_err_count, 2);
    zeros(7); vt(4'hB);
    chk("s2_resync", o_resync, 4'hF);
    chk("s2_err3", o_err_count, 3);
    chk("s2_count", o_resync_count, 1);
    chk("s2_align_drop", o_align_status, 0);
    vt('0);   chk("s2_hold2", o_resync, 4'hF);
    vt('0);   chk("s2_hold_end", o_resync, 0);

    // 3: stuck-zero tags, then good AM on the second slot.
    go_aligned();
    zeros(23); chk("s3_err2", o_err_count, 2);
    vt('0);
    chk("s3_err3", o_err_count, 3);
    chk("s3_resync", o_resync, 4'hF);
    chk("s3_count", o_resync_count, 2);
    zeros(2);
    go_aligned();
    zeros(8);  chk("s3b_err1", o_err_count, 1);
    zeros(7); vt(4'hF);
    chk("s3b_err0", o_err_count, 0);
    chk("s3b_align", o_align_status, 1);

    // 4: deskew timeout with valid gaps, then skew+done together.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 31; k++) begin
      vt('0);
      if (k % 4 == 0) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    end
    chk("s4_pre_timeout", o_resync, 0);
    vt('0);
    chk("s4_timeout", o_resync, 4'hF);
    chk("s4_count", o_resync_count, 3);
    zeros(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0);
    chk("s4_skew_resync", o_resync, 4'hF);
    chk("s4_skew_align", o_align_status, 0);
    chk("s4_skew_count", o_resync_count, 4);
    zeros(2);

    // 5: lock loss in ALIGNED; valid gaps stall the period counter.
    go_aligned();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("s5_lock_drop", o_align_status, 0);
    go_aligned();
    zeros(5);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB);
    zeros(2); chk("s5_gap_err0", o_err_count, 0);
    vt('0);   chk("s5_gap_err1", o_err_count, 1);

    // 6: reset mid-resync, then enable-low freeze.
    vt(4'hB); vt(4'hB);
    chk("s6_resync", o_resync, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("s6_rst_resync", o_resync, 0);
    chk("s6_rst_align", o_align_status, 0);
    chk("s6_rst_err", o_err_count, 0);
    chk("s6_rst_count", o_resync_count, 0);
    go_aligned();
    vt(4'hB);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB);
      chk("s6_freeze_align", o_align_status, 1);
      chk("s6_freeze_err", o_err_count, 1);
    end
    vt('0);
    chk("s6_resume_err", o_err_count, 1);

    // Random phase against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] t;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5) t = '0;
      else if (sel <= 7) t = 4'hF;
      else if (sel == 8) t = N'($urandom);
      else t = '0;
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0), t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
